// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator and registered pixel output stage.
// Define VGA_CLKDIV2_EN to run pixels at clk/2 (50 MHz board clock); otherwise one pixel per clk.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] color,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       vsync,
  output logic       hsync,
  output logic [2:0] rgb,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic hsync_win;
  logic vsync_win;

`ifdef VGA_CLKDIV2_EN
  logic phase;

  // Phase 0 is a tick, so the first clk after reset release advances the scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase <= 1'b0;
    else      phase <= ~phase;
  end

  assign pixel_tick = ~phase;
`else
  assign pixel_tick = 1'b1;
`endif

  assign video_on  = (x < 10'(H_VISIBLE)) && (y < 10'(V_VISIBLE));
  assign hsync_win = (x >= H_SYNC_LO) && (x < H_SYNC_HI);
  assign vsync_win = (y >= V_SYNC_LO) && (y < V_SYNC_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pixel_tick) begin
        if (x == H_LAST) begin
          x <= '0;
          if (y == V_LAST) begin
            y           <= '0;
            frame_start <= 1'b1;
          end else begin
            y <= y + 10'd1;
          end
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

  // Pins are decoded from the pre-advance counters, so they trail x/y by one pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else if (pixel_tick) begin
      hsync <= ~hsync_win;
      vsync <= ~vsync_win;
      rgb   <= video_on ? color : 3'b000;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a scaled-down raster and a pixel-index model.
module tb_vga_sync_gen;

  localparam int unsigned HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int unsigned VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FR = HT * VT;
`ifdef VGA_CLKDIV2_EN
  localparam int unsigned CPT = 2;
`else
  localparam int unsigned CPT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] color = '0;
  logic [9:0] x, y;
  logic       vsync, hsync, video_on, pixel_tick, frame_start;
  logic [2:0] rgb;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .color(color), .x(x), .y(y),
    .vsync(vsync), .hsync(hsync), .rgb(rgb), .video_on(video_on),
    .pixel_tick(pixel_tick), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Model state: c = clk edges since release, n = pixels advanced since release.
  int unsigned c = 0, n = 0;
  logic [2:0]  last_col = '0;
  bit          in_reset = 1'b1;
  bit          last_tick = 1'b0;
  int          passes = 0, checks = 0;
  int unsigned vs_falls = 0;
  logic        vs_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d (n=%0d)", tag, obs, exp, n);
  endtask

  function automatic bit tick_at(input int unsigned cc);
    return (cc % CPT) == 0;
  endfunction

  task automatic check_all();
    int unsigned p, ex, ey, q, qx, qy;
    logic eh, ev, efs;
    logic [2:0] er;
    p  = n % FR;
    ex = p % HT;
    ey = p / HT;
    if (n == 0) begin
      eh = 1'b1; ev = 1'b1; er = 3'b000;
    end else begin
      q  = (n - 1) % FR;
      qx = q % HT;
      qy = q / HT;
      eh = !(qx >= HV + HF && qx < HV + HF + HS);
      ev = !(qy >= VV + VF && qy < VV + VF + VS);
      er = (qx < HV && qy < VV) ? last_col : 3'b000;
    end
    efs = !in_reset && last_tick && n > 0 && p == 0;
    check("x", 32'(x), ex);
    check("y", 32'(y), ey);
    check("hsync", 32'(hsync), 32'(eh));
    check("vsync", 32'(vsync), 32'(ev));
    check("rgb", 32'(rgb), 32'(er));
    check("video_on", 32'(video_on), 32'(ex < HV && ey < VV));
    check("frame_start", 32'(frame_start), 32'(efs));
    check("pixel_tick", 32'(pixel_tick), 32'(tick_at(c)));
  endtask

  task automatic step(input logic [2:0] col);
    color = col;
    @(posedge clk);
    if (!in_reset) begin
      last_tick = tick_at(c);
      if (last_tick) begin
        n++;
        last_col = col;
      end
      c++;
    end
    @(negedge clk);
    check_all();
    if (vs_prev && !vsync) vs_falls++;
    vs_prev = vsync;
  endtask

  function automatic int unsigned expected_falls(input int unsigned ticks);
    int unsigned s;
    s = (VV + VF) * HT;
    if (ticks == 0 || ticks - 1 < s) return 0;
    return (ticks - 1 - s) / FR + 1;
  endfunction

  initial begin
    int unsigned guard;
    // Reset held with clk running.
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b1;
    in_reset = 1'b0;

    // One frame with constant colour exercises blanking, then random colours.
    repeat (FR * CPT) step(3'b110);
    repeat (FR * CPT + 3 * HT * CPT) step(3'($urandom));
    check("vsync_falls", vs_falls, expected_falls(n));

    // Walk to mid-frame and reset asynchronously between edges.
    guard = 0;
    while (!(((n % FR) % HT) == 9 && ((n % FR) / HT) == 5) && guard < 2 * FR * CPT) begin
      step(3'($urandom));
      guard++;
    end
    check("midframe_reached", 32'(guard < 2 * FR * CPT), 32'd1);
    #2 rst = 1'b0;
    in_reset = 1'b1;
    n = 0; c = 0; last_tick = 1'b0; last_col = '0;
    #1 check_all();
    repeat (3) step(3'($urandom));
    rst = 1'b1;
    in_reset = 1'b0;
    vs_falls = 0;
    vs_prev = 1'b1;
    repeat (FR * CPT + 2 * HT * CPT) step(3'($urandom));
    check("vsync_falls_after_reset", vs_falls, expected_falls(n));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
